bgpu_axi_mem_responder: RTL and testbench
=========================================

// Module: bgpu_axi_mem_responder
// PURPOSE
// - AXI4 subordinate backed by an on-chip word array. Answers the bgpu_soc external memory-controller AXI port.
// - Stands in for the DDR controller when the external controller is not used: on-FPGA smoke tests and simulation.
// - Independent read and write FSMs; one outstanding burst per direction.
// PARAMETERS
// - AddrWidth  30            AXI address width in bits
// - DataWidth  512           AXI data width in bits, a power of two and at least 32
// - IdWidth    6             AXI ID width in bits
// - MemWords   4096          depth of the backing array in DataWidth words, a power of two
// - axi_req_t  logic         AXI request struct type
// - axi_rsp_t  logic         AXI response struct type
// PORTS
// - clk_i      in   1        clock; every register is on its rising edge
// - rst_ni     in   1        asynchronous active-low reset
// - axi_req_i  in   struct   AXI request: AW, W, AR channels plus b_ready and r_ready
// - axi_rsp_o  out  struct   AXI response: aw_ready, w_ready, ar_ready, B channel, R channel
// BEHAVIOUR
// - Word index = addr[log2(MemWords)+OB-1:OB], where OB = log2(DataWidth/8). Upper address bits are handled under CONFIGURATION.
// - Beat address advance:
//   - INCR and WRAP both advance by 2^size bytes per beat; WRAP is treated as INCR.
//   - FIXED keeps the same address on every beat.
// - Reset state:
//   - Both FSMs in IDLE; all valid outputs 0; B and R payloads 0.
//   - aw_ready = ar_ready = 1 in the first cycle after rst_ni deasserts.
//   - Array contents are not reset.
// - Write FSM:
//   - W_IDLE: aw_ready=1. On the AW handshake, latch id, addr, len, size and burst; go to W_DATA.
//   - W_DATA: w_ready=1. Each W handshake writes the bytes selected by strb, then advances the address and the beat counter.
//   - W_DATA ends after beat len+1 and goes to W_RESP; w.last is not used to end the burst.
//   - If w.last disagrees with the beat count, the response is SLVERR; the data is still written.
//   - W_RESP: b_valid=1 with the latched id. Hold b_valid and B stable until b_ready, then go to W_IDLE.
//   - aw_ready is 0 in W_DATA and W_RESP.
// - Read FSM:
//   - R_IDLE: ar_ready=1. On the AR handshake, latch the fields; go to R_READ.
//   - R_READ: issue a synchronous array read of the current word; go to R_SEND.
//   - R_SEND: r_valid=1; r.data is registered; r.last=1 on beat len. Hold R stable while r_ready=0.
//   - On the R handshake: if last, go to R_IDLE; otherwise advance the address and go to R_READ.
//   - Latency: AR handshake in cycle N gives the first r_valid in cycle N+2. Maximum throughput is 1 beat per 2 cycles.
// - Simultaneous events:
//   - AW and AR handshakes in the same cycle are both accepted.
//   - A write and a read to the same word in the same cycle: the read returns the old data (read-first).
// - Reset mid-operation: both FSMs go to IDLE immediately. In-flight bursts are dropped; no B or R is produced for them.
// - len is 8 bits, so bursts are 1..256 beats. The beat counter is 8 bits; the address counter wraps modulo 2^AddrWidth.
// CONFIGURATION
// - Macro BGPU_AXI_MEM_RANGE_CHECK_EN.
// - Defined:
//   - An access is out of range when any address bit at or above log2(MemWords)+OB is set. Each beat is checked.
//   - Out-of-range write beats are dropped; the burst's B is SLVERR.
//   - Out-of-range read beats return data 0 with resp SLVERR.
//   - Beat count, last and timing are unchanged.
// - Undefined: upper address bits are ignored, so the array aliases modulo MemWords. resp is always OKAY, except the w.last mismatch case.
// TESTING
// - Single write then read: AW addr 0x40, len 0, full strb, data D -> B OKAY with matching id; AR 0x40 len 0 -> R data D, last=1, r_valid 2 cycles after AR.
// - INCR burst: write len 7 to 0x0, data 0..7; read back len 7 -> eight beats 0..7 in order; last only on beat 8; resp OKAY.
// - Partial strobe: preload all-ones, write strb=0x1 with data 0x00 -> readback byte 0 = 0x00, other bytes 0xFF.
// - Backpressure: r_ready low for 5 cycles mid-burst, b_ready low for 3 cycles -> payloads stable, no beat lost or duplicated.
// - Concurrency: AW and AR in the same cycle to different words -> both accepted; B and R correct and independent.
// - Range check (macro on): AR addr = MemWords*DataWidth/8 -> resp SLVERR, data 0; with macro off -> data from word 0.

Source files
------------

// File: rtl/bgpu_axi_mem_responder.sv
// AXI4 subordinate backed by an on-chip word array, one outstanding burst per direction.
// Optional macro BGPU_AXI_MEM_RANGE_CHECK_EN: beats above the array answer SLVERR instead of aliasing.
package bgpu_axi_mem_pkg;
    localparam int unsigned AW = 30;
    localparam int unsigned DW = 512;
    localparam int unsigned IW = 6;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } ax_chan_t;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic            last;
    } w_chan_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_chan_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } axi_rsp_t;
endpackage

module bgpu_axi_mem_responder #(
    parameter int unsigned AddrWidth = 30,
    parameter int unsigned DataWidth = 512,
    parameter int unsigned IdWidth   = 6,
    parameter int unsigned MemWords  = 4096,
    parameter type axi_req_t = bgpu_axi_mem_pkg::axi_req_t,
    parameter type axi_rsp_t = bgpu_axi_mem_pkg::axi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_rsp_o
);
    localparam int unsigned OB = $clog2(DataWidth / 8);
    localparam int unsigned XB = $clog2(MemWords);
    localparam int unsigned NB = DataWidth / 8;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] BurstFixed = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_SEND} r_state_e;

    logic [DataWidth-1:0] r_mem [MemWords];

    w_state_e             r_wstate;
    logic [IdWidth-1:0]   r_wid;
    logic [AddrWidth-1:0] r_waddr;
    logic [7:0]           r_wlen;
    logic [2:0]           r_wsize;
    logic [1:0]           r_wburst;
    logic [7:0]           r_wbeat;
    logic                 r_werr;
    logic                 r_aw_ready;
    logic                 r_w_ready;
    logic                 r_b_valid;
    logic [IdWidth-1:0]   r_b_id;
    logic [1:0]           r_b_resp;

    r_state_e             r_rstate;
    logic [IdWidth-1:0]   r_rid;
    logic [AddrWidth-1:0] r_raddr;
    logic [7:0]           r_rlen;
    logic [2:0]           r_rsize;
    logic [1:0]           r_rburst;
    logic [7:0]           r_rbeat;
    logic                 r_ar_ready;
    logic                 r_r_valid;
    logic [DataWidth-1:0] r_r_data;
    logic [1:0]           r_r_resp;
    logic                 r_r_last;

    logic          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic          w_w_last_beat, w_werr_next, w_w_oor, w_r_oor;
    logic [XB-1:0] w_widx, w_ridx;

    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a,
                                                       input logic [2:0] s,
                                                       input logic [1:0] b);
        if (b == BurstFixed) return a;
        return a + (AddrWidth'(1) << s);
    endfunction

    assign w_aw_hs = axi_req_i.aw_valid & r_aw_ready;
    assign w_w_hs  = axi_req_i.w_valid & r_w_ready;
    assign w_b_hs  = r_b_valid & axi_req_i.b_ready;
    assign w_ar_hs = axi_req_i.ar_valid & r_ar_ready;
    assign w_r_hs  = r_r_valid & axi_req_i.r_ready;

    assign w_widx = r_waddr[XB+OB-1:OB];
    assign w_ridx = r_raddr[XB+OB-1:OB];

`ifdef BGPU_AXI_MEM_RANGE_CHECK_EN
    assign w_w_oor = |r_waddr[AddrWidth-1:XB+OB];
    assign w_r_oor = |r_raddr[AddrWidth-1:XB+OB];
`else
    assign w_w_oor = 1'b0;
    assign w_r_oor = 1'b0;
`endif

    // The beat count alone ends a burst; a w.last that disagrees only poisons the response.
    assign w_w_last_beat = (r_wbeat == r_wlen);
    assign w_werr_next   = r_werr | (axi_req_i.w.last != w_w_last_beat) | w_w_oor;

    always_ff @(posedge clk_i) begin
        if (w_w_hs && !w_w_oor) begin
            for (int b = 0; b < NB; b++) begin
                if (axi_req_i.w.strb[b]) r_mem[w_widx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wstate   <= W_IDLE;
            r_wid      <= '0;
            r_waddr    <= '0;
            r_wlen     <= '0;
            r_wsize    <= '0;
            r_wburst   <= '0;
            r_wbeat    <= '0;
            r_werr     <= 1'b0;
            r_aw_ready <= 1'b1;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_id     <= '0;
            r_b_resp   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: if (w_aw_hs) begin
                    r_wid      <= axi_req_i.aw.id;
                    r_waddr    <= axi_req_i.aw.addr;
                    r_wlen     <= axi_req_i.aw.len;
                    r_wsize    <= axi_req_i.aw.size;
                    r_wburst   <= axi_req_i.aw.burst;
                    r_wbeat    <= '0;
                    r_werr     <= 1'b0;
                    r_aw_ready <= 1'b0;
                    r_w_ready  <= 1'b1;
                    r_wstate   <= W_DATA;
                end
                W_DATA: if (w_w_hs) begin
                    r_waddr <= next_addr(r_waddr, r_wsize, r_wburst);
                    r_wbeat <= r_wbeat + 8'd1;
                    r_werr  <= w_werr_next;
                    if (w_w_last_beat) begin
                        r_w_ready <= 1'b0;
                        r_b_valid <= 1'b1;
                        r_b_id    <= r_wid;
                        r_b_resp  <= w_werr_next ? RespSlvErr : RespOkay;
                        r_wstate  <= W_RESP;
                    end
                end
                W_RESP: if (w_b_hs) begin
                    r_b_valid  <= 1'b0;
                    r_aw_ready <= 1'b1;
                    r_wstate   <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rstate   <= R_IDLE;
            r_rid      <= '0;
            r_raddr    <= '0;
            r_rlen     <= '0;
            r_rsize    <= '0;
            r_rburst   <= '0;
            r_rbeat    <= '0;
            r_ar_ready <= 1'b1;
            r_r_valid  <= 1'b0;
            r_r_data   <= '0;
            r_r_resp   <= '0;
            r_r_last   <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: if (w_ar_hs) begin
                    r_rid      <= axi_req_i.ar.id;
                    r_raddr    <= axi_req_i.ar.addr;
                    r_rlen     <= axi_req_i.ar.len;
                    r_rsize    <= axi_req_i.ar.size;
                    r_rburst   <= axi_req_i.ar.burst;
                    r_rbeat    <= '0;
                    r_ar_ready <= 1'b0;
                    r_rstate   <= R_READ;
                end
                R_READ: begin
                    r_r_data  <= w_r_oor ? '0 : r_mem[w_ridx];
                    r_r_resp  <= w_r_oor ? RespSlvErr : RespOkay;
                    r_r_last  <= (r_rbeat == r_rlen);
                    r_r_valid <= 1'b1;
                    r_rstate  <= R_SEND;
                end
                R_SEND: if (w_r_hs) begin
                    r_r_valid <= 1'b0;
                    if (r_r_last) begin
                        r_ar_ready <= 1'b1;
                        r_rstate   <= R_IDLE;
                    end else begin
                        r_raddr  <= next_addr(r_raddr, r_rsize, r_rburst);
                        r_rbeat  <= r_rbeat + 8'd1;
                        r_rstate <= R_READ;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = r_aw_ready;
        axi_rsp_o.w_ready  = r_w_ready;
        axi_rsp_o.b_valid  = r_b_valid;
        axi_rsp_o.b.id     = r_b_id;
        axi_rsp_o.b.resp   = r_b_resp;
        axi_rsp_o.ar_ready = r_ar_ready;
        axi_rsp_o.r_valid  = r_r_valid;
        axi_rsp_o.r.id     = r_rid;
        axi_rsp_o.r.data   = r_r_data;
        axi_rsp_o.r.resp   = r_r_resp;
        axi_rsp_o.r.last   = r_r_last;
    end
endmodule

// File: tb/tb_bgpu_axi_mem_responder.sv
// Scoreboard bench for bgpu_axi_mem_responder: drivers push expected B/R into queues, a monitor pops on handshakes.
module tb_bgpu_axi_mem_responder;
    import bgpu_axi_mem_pkg::*;

    localparam int RW = 6 + 512 + 2 + 1;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, INCR = 2'b01, FIXED = 2'b00;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    axi_req_t req;
    axi_rsp_t rsp;

    always #5 clk = ~clk;

    bgpu_axi_mem_responder dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .axi_req_i(req),
        .axi_rsp_o(rsp)
    );

    logic [RW-1:0] exp_r_q[$];
    logic [7:0]    exp_b_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic push_r(input logic [5:0] id, input logic [511:0] data, input logic [1:0] resp, input logic last);
        r_chan_t e;
        e.id = id; e.data = data; e.resp = resp; e.last = last;
        exp_r_q.push_back(e);
    endtask

    // Monitor: compare on handshakes, and check payload stability while stalled.
    logic    prev_r_stall = 1'b0, prev_b_stall = 1'b0;
    r_chan_t prev_r;
    b_chan_t prev_b;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_r_stall) begin
                check("r_hold_valid", RW'(rsp.r_valid), RW'(1));
                check("r_hold_payload", rsp.r, prev_r);
            end
            if (prev_b_stall) begin
                check("b_hold_valid", RW'(rsp.b_valid), RW'(1));
                check("b_hold_payload", RW'(rsp.b), RW'(prev_b));
            end
            if (rsp.r_valid && req.r_ready) begin
                if (exp_r_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_unexpected got %h exp none", rsp.r);
                end else check("r_beat", rsp.r, exp_r_q.pop_front());
            end
            if (rsp.b_valid && req.b_ready) begin
                if (exp_b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected got %h exp none", rsp.b);
                end else check("b_resp", RW'(rsp.b), RW'(exp_b_q.pop_front()));
            end
            prev_r_stall = rsp.r_valid && !req.r_ready;
            prev_r       = rsp.r;
            prev_b_stall = rsp.b_valid && !req.b_ready;
            prev_b       = rsp.b;
        end
    end

    task automatic aw_send(input logic [5:0] id, input logic [29:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        logic hs = 1'b0;
        req.aw.id = id; req.aw.addr = addr; req.aw.len = len; req.aw.size = 3'd6; req.aw.burst = burst;
        req.aw_valid = 1'b1;
        while (!hs) begin
            @(negedge clk); hs = rsp.aw_ready;
            @(posedge clk); #1;
            n++;
            if (!hs && n > 100) begin
                checks++; errors++;
                $display("FAIL aw_timeout got no aw_ready exp handshake");
                break;
            end
        end
        req.aw_valid = 1'b0;
    endtask

    task automatic ar_send(input logic [5:0] id, input logic [29:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        logic hs = 1'b0;
        req.ar.id = id; req.ar.addr = addr; req.ar.len = len; req.ar.size = 3'd6; req.ar.burst = burst;
        req.ar_valid = 1'b1;
        while (!hs) begin
            @(negedge clk); hs = rsp.ar_ready;
            @(posedge clk); #1;
            n++;
            if (!hs && n > 100) begin
                checks++; errors++;
                $display("FAIL ar_timeout got no ar_ready exp handshake");
                break;
            end
        end
        req.ar_valid = 1'b0;
    endtask

    task automatic w_send(input logic [511:0] data, input logic [63:0] strb, input logic last);
        int n = 0;
        logic hs = 1'b0;
        req.w.data = data; req.w.strb = strb; req.w.last = last;
        req.w_valid = 1'b1;
        while (!hs) begin
            @(negedge clk); hs = rsp.w_ready;
            @(posedge clk); #1;
            n++;
            if (!hs && n > 100) begin
                checks++; errors++;
                $display("FAIL w_timeout got no w_ready exp handshake");
                break;
            end
        end
        req.w_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_r_q.size() != 0 || exp_b_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_r_q.size() != 0 || exp_b_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got r=%0d b=%0d pending exp 0", exp_r_q.size(), exp_b_q.size());
            exp_r_q.delete();
            exp_b_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got no finish exp finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] d_a, d_b, d_c, pat, d_g, d_h;
        d_a = {16{32'hDEADBEEF}};
        d_b = {64{8'h3C}};
        d_c = {8{64'h0123_4567_89AB_CDEF}};
        d_g = {16{32'hA5A5_0F0F}};
        d_h = {16{32'h1234_5678}};
        pat = '1;
        pat[7:0] = 8'h00;

        req = '0;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_b_valid", RW'(rsp.b_valid), RW'(0));
        check("rst_r_valid", RW'(rsp.r_valid), RW'(0));
        check("rst_r_payload", rsp.r, RW'(0));
        check("rst_b_payload", RW'(rsp.b), RW'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_aw_ready", RW'(rsp.aw_ready), RW'(1));
        check("rst_ar_ready", RW'(rsp.ar_ready), RW'(1));
        @(posedge clk); #1;

        // Single write then read with latency check.
        exp_b_q.push_back({6'h11, OKAY});
        aw_send(6'h11, 30'h40, 8'd0, INCR);
        w_send(d_a, '1, 1'b1);
        wait_done();
        push_r(6'h22, d_a, OKAY, 1'b1);
        ar_send(6'h22, 30'h40, 8'd0, INCR);
        @(negedge clk); check("lat_cycle1", RW'(rsp.r_valid), RW'(0));
        @(negedge clk); check("lat_cycle2", RW'(rsp.r_valid), RW'(1));
        wait_done();

        // INCR burst of 8 beats over words 0..7.
        exp_b_q.push_back({6'h03, OKAY});
        aw_send(6'h03, 30'h0, 8'd7, INCR);
        for (int i = 0; i < 8; i++) w_send(512'(i), '1, i == 7);
        wait_done();
        for (int i = 0; i < 8; i++) push_r(6'h04, 512'(i), OKAY, i == 7);
        ar_send(6'h04, 30'h0, 8'd7, INCR);
        wait_done();

        // Partial strobe on word 2.
        exp_b_q.push_back({6'h05, OKAY});
        aw_send(6'h05, 30'h80, 8'd0, INCR);
        w_send('1, '1, 1'b1);
        wait_done();
        exp_b_q.push_back({6'h06, OKAY});
        aw_send(6'h06, 30'h80, 8'd0, INCR);
        w_send('0, 64'h1, 1'b1);
        wait_done();
        push_r(6'h07, pat, OKAY, 1'b1);
        ar_send(6'h07, 30'h80, 8'd0, INCR);
        wait_done();

        // R backpressure mid-burst (word 2 now holds pat).
        for (int i = 0; i < 4; i++) push_r(6'h08, (i == 2) ? pat : 512'(i), OKAY, i == 3);
        ar_send(6'h08, 30'h0, 8'd3, INCR);
        repeat (3) @(posedge clk); #1;
        req.r_ready = 1'b0;
        repeat (5) @(posedge clk); #1;
        req.r_ready = 1'b1;
        wait_done();

        // B backpressure.
        req.b_ready = 1'b0;
        exp_b_q.push_back({6'h09, OKAY});
        aw_send(6'h09, 30'hC0, 8'd0, INCR);
        w_send(d_b, '1, 1'b1);
        repeat (3) @(posedge clk); #1;
        req.b_ready = 1'b1;
        wait_done();

        // AW and AR in the same cycle to different words.
        exp_b_q.push_back({6'h0A, OKAY});
        push_r(6'h0B, d_b, OKAY, 1'b1);
        fork
            aw_send(6'h0A, 30'h100, 8'd0, INCR);
            ar_send(6'h0B, 30'hC0, 8'd0, INCR);
        join
        w_send(d_c, '1, 1'b1);
        wait_done();
        push_r(6'h0C, d_c, OKAY, 1'b1);
        ar_send(6'h0C, 30'h100, 8'd0, INCR);
        wait_done();

        // FIXED burst: every beat lands on word 10, reads repeat it.
        exp_b_q.push_back({6'h0D, OKAY});
        aw_send(6'h0D, 30'h280, 8'd2, FIXED);
        w_send(d_a, '1, 1'b0);
        w_send(d_b, '1, 1'b0);
        w_send(d_c, '1, 1'b1);
        wait_done();
        push_r(6'h0E, d_c, OKAY, 1'b0);
        push_r(6'h0E, d_c, OKAY, 1'b1);
        ar_send(6'h0E, 30'h280, 8'd1, FIXED);
        wait_done();

        // Early w.last: SLVERR, data still written, burst still two beats.
        exp_b_q.push_back({6'h0F, SLVERR});
        aw_send(6'h0F, 30'h300, 8'd1, INCR);
        w_send(d_g, '1, 1'b1);
        w_send(d_h, '1, 1'b0);
        wait_done();
        push_r(6'h10, d_g, OKAY, 1'b0);
        push_r(6'h10, d_h, OKAY, 1'b1);
        ar_send(6'h10, 30'h300, 8'd1, INCR);
        wait_done();

        // Address just above the array.
        exp_b_q.push_back({6'h12, OKAY});
        aw_send(6'h12, 30'h0, 8'd0, INCR);
        w_send(d_g, '1, 1'b1);
        wait_done();
`ifdef BGPU_AXI_MEM_RANGE_CHECK_EN
        push_r(6'h13, '0, SLVERR, 1'b1);
        ar_send(6'h13, 30'h40000, 8'd0, INCR);
        wait_done();
        exp_b_q.push_back({6'h14, SLVERR});
        aw_send(6'h14, 30'h40000, 8'd0, INCR);
        w_send(d_h, '1, 1'b1);
        wait_done();
        push_r(6'h15, d_g, OKAY, 1'b1);
`else
        push_r(6'h13, d_g, OKAY, 1'b1);
        ar_send(6'h13, 30'h40000, 8'd0, INCR);
        wait_done();
        exp_b_q.push_back({6'h14, OKAY});
        aw_send(6'h14, 30'h40000, 8'd0, INCR);
        w_send(d_h, '1, 1'b1);
        wait_done();
        push_r(6'h15, d_h, OKAY, 1'b1);
`endif
        ar_send(6'h15, 30'h0, 8'd0, INCR);
        wait_done();

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
